regfile_param: RTL and testbench
================================

# regfile_param

Parametrised register file for the CPU datapath: the next generation of the 16 x 24-bit RegisterFile. It has configurable data width and address width, two asynchronous read ports and one synchronous write port, and an optional hardwired-zero R0. It also adds a per-register busy scoreboard so the pipelined control unit can detect read-after-write hazards. An optional write-to-read bypass is available. The block sits between decode (Rs/Rt/Rd fields) and writeback (WriteD).

## Interface
Parameters:
- DATA_W, 24, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W registers
- ZERO_REG, 1, 1 = R0 reads 0, ignores writes, never marked busy; 0 = R0 is an ordinary register

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all registers and busy bits
- Rs  input  ADDR_W  read address, port 1
- Rt  input  ADDR_W  read address, port 2
- ReadR1  output  DATA_W  contents of register Rs (combinational)
- ReadR2  output  DATA_W  contents of register Rt (combinational)
- Rd  input  ADDR_W  write address
- WriteD  input  DATA_W  write data
- RegWrite  input  1  write enable; also clears busy bit of Rd
- Issue  input  1  instruction issued that will later write IssueRd
- IssueRd  input  ADDR_W  destination of the issued instruction
- Busy1  output  1  register Rs has a pending write
- Busy2  output  1  register Rt has a pending write
- Stall  output  1  Busy1 | Busy2

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus a 2**ADDR_W busy vector.
- Write: on a rising clock edge with RegWrite=1, reg[Rd] <= WriteD. When ZERO_REG=1 and Rd=0, the write is dropped.
- Read: ReadR1 = reg[Rs] and ReadR2 = reg[Rt], purely combinational. Both ports may address the same register.
- ZERO_REG=1: any read of address 0 returns 0 regardless of stored contents.
- Scoreboard update per edge, for each register i:
  - set if Issue=1 and IssueRd=i;
  - else clear if RegWrite=1 and Rd=i;
  - else hold.
  - Set has priority: when issue and writeback target the same register in one cycle, the register stays busy because a newer producer is in flight.
- When ZERO_REG=1, busy[0] is constantly 0.
- Busy1 = busy[Rs] and Busy2 = busy[Rt], combinational, subject to the bypass rule below.
- RegWrite to a non-busy register is legal: data is written and busy stays 0.
- Issue=1 on an already-busy register keeps it busy. There is no counting; the last writeback clears it.
- No width arithmetic is performed. WriteD is stored exactly, and addresses are full-range with no out-of-range case.

## Timing
- Reset (asynchronous assert): all registers = 0 and all busy bits = 0 immediately. ReadR1 = ReadR2 = 0 and Busy1 = Busy2 = Stall = 0 while reset is high. RegWrite and Issue are ignored while reset is high.
- Reset release is synchronised externally; the first update happens on the first rising edge with reset low.
- Write latency: without bypass, data written at edge N is visible on ReadR1/ReadR2 after edge N, i.e. in cycle N+1.
- Busy latency: Issue at edge N makes Busy visible from cycle N+1. RegWrite at edge N clears busy from cycle N+1 (no bypass).
- Reset asserted mid-cycle with RegWrite=1: the write is lost and the register reads 0.

## Configuration
- REGFILE_BYPASS_EN defined: in the same cycle that RegWrite=1 and Rd = Rs (and Rd is not a zero R0), ReadR1 = WriteD and Busy1 = 0. The same applies to Rt, ReadR2 and Busy2. Stall follows the bypassed Busy values. Read latency is 0 cycles relative to the writeback cycle.
- REGFILE_BYPASS_EN undefined: reads and busy flags reflect stored state only. The writeback cycle still shows old data and Busy=1.
- Issue is never bypassed in either mode: a same-cycle Issue does not raise Busy combinationally.

## Test plan
- Reset: load reg8=5, assert reset asynchronously mid-cycle → ReadR1=0 for Rs=8 immediately. Busy1=Busy2=Stall=0.
- Write/read, matching the legacy sequence: write Rd=8 WriteD=5, then Rd=9 WriteD=7, then RegWrite=0, Rs=8, Rt=9 → ReadR1=5 and ReadR2=7.
- Zero register: ZERO_REG=1, write Rd=0 WriteD=24'hABCDEF, then Rs=0 → ReadR1=0. With ZERO_REG=0 the same sequence → ReadR1=24'hABCDEF.
- Scoreboard:
  - Issue IssueRd=3 at edge N, Rs=3 → Busy1=1 and Stall=1 from cycle N+1.
  - RegWrite Rd=3 WriteD=9 at edge M → Busy1=0 and ReadR1=9 from M+1.
  - Same-cycle Issue and RegWrite to register 3 → Busy1 remains 1.
- Bypass: register 5 busy holding 1, then RegWrite Rd=5 WriteD=42 with Rs=Rt=5 in the same cycle:
  - with REGFILE_BYPASS_EN → ReadR1=ReadR2=42 and Stall=0 in that cycle;
  - without REGFILE_BYPASS_EN → ReadR1=1 and Stall=1 in that cycle, then 42 and 0 after the edge.
- Parametrisation: DATA_W=32, ADDR_W=5, write Rd=31 WriteD=32'hFFFF_FFFF → ReadR2=32'hFFFF_FFFF for Rt=31. Registers 0..30 remain unaffected.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: two async read ports, one sync write port, optional zero R0,
// per-register busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_param #(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    output logic [DATA_W-1:0] ReadR1,
    output logic [DATA_W-1:0] ReadR2,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [DATA_W-1:0] WriteD,
    input  logic              RegWrite,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] IssueRd,
    output logic              Busy1,
    output logic              Busy2,
    output logic              Stall
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              w_zero_rd;
    logic              w_wr_en;
    logic              w_byp1;
    logic              w_byp2;

    assign w_zero_rd = (ZERO_REG != 0) && (Rd == ADDR_W'(0));
    assign w_wr_en   = RegWrite && !w_zero_rd;

    // Issue sets (newer producer wins), writeback clears, zero R0 never busy
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (Issue && (IssueRd == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end else if (RegWrite && (Rd == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[Rd] <= WriteD;
            end
            r_busy <= w_busy_nxt;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_byp1 = w_wr_en && !reset && (Rd == Rs);
    assign w_byp2 = w_wr_en && !reset && (Rd == Rt);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_comb begin
        ReadR1 = r_mem[Rs];
        ReadR2 = r_mem[Rt];
        if (w_byp1) begin
            ReadR1 = WriteD;
        end
        if (w_byp2) begin
            ReadR2 = WriteD;
        end
        if ((ZERO_REG != 0) && (Rs == ADDR_W'(0))) begin
            ReadR1 = '0;
        end
        if ((ZERO_REG != 0) && (Rt == ADDR_W'(0))) begin
            ReadR2 = '0;
        end
    end

    assign Busy1 = r_busy[Rs] && !w_byp1;
    assign Busy2 = r_busy[Rt] && !w_byp2;
    assign Stall = Busy1 || Busy2;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: vector table, hand sequences (bypass, async reset, wide config)
// and randomized traffic against an array-based reference model.
module tb_regfile_param;

    logic        clock;
    logic        reset;
    logic [3:0]  Rs, Rt, Rd, IssueRd;
    logic [23:0] WriteD, ReadR1, ReadR2;
    logic        RegWrite, Issue, Busy1, Busy2, Stall;

    logic [4:0]  wRs, wRt, wRd, wIssueRd;
    logic [31:0] wWriteD, wReadR1, wReadR2;
    logic        wRegWrite, wIssue, wBusy1, wBusy2, wStall;

    int n_chk;
    int n_fail;

    regfile_param dut (
        .clock(clock), .reset(reset), .Rs(Rs), .Rt(Rt),
        .ReadR1(ReadR1), .ReadR2(ReadR2), .Rd(Rd), .WriteD(WriteD),
        .RegWrite(RegWrite), .Issue(Issue), .IssueRd(IssueRd),
        .Busy1(Busy1), .Busy2(Busy2), .Stall(Stall)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_w (
        .clock(clock), .reset(reset), .Rs(wRs), .Rt(wRt),
        .ReadR1(wReadR1), .ReadR2(wReadR2), .Rd(wRd), .WriteD(wWriteD),
        .RegWrite(wRegWrite), .Issue(wIssue), .IssueRd(wIssueRd),
        .Busy1(wBusy1), .Busy2(wBusy2), .Stall(wStall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [23:0] wd;
        logic        iss;
        logic [3:0]  ird;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [23:0] e1;
        logic [23:0] e2;
        logic        eb1;
        logic        eb2;
    } vec_t;

    vec_t tbl[15];

    // reference model state
    logic [23:0] m_mem [16];
    bit          m_busy [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] rd, input logic [23:0] wd,
                                input logic iss, input logic [3:0] ird,
                                input logic [3:0] rs, input logic [3:0] rt,
                                input logic [23:0] e1, input logic [23:0] e2,
                                input logic eb1, input logic eb2);
        vec_t v;
        v.we = we; v.rd = rd; v.wd = wd; v.iss = iss; v.ird = ird;
        v.rs = rs; v.rt = rt; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [3:0] rd, input logic [23:0] wd,
                         input logic iss, input logic [3:0] ird,
                         input logic [3:0] rs, input logic [3:0] rt);
        RegWrite = we; Rd = rd; WriteD = wd; Issue = iss; IssueRd = ird; Rs = rs; Rt = rt;
    endtask

    task automatic chk_all(input string tag, input logic [23:0] e1, input logic [23:0] e2,
                           input logic eb1, input logic eb2);
        chk({tag, ".ReadR1"}, 32'(ReadR1), 32'(e1));
        chk({tag, ".ReadR2"}, 32'(ReadR2), 32'(e2));
        chk({tag, ".Busy1"}, 32'(Busy1), 32'(eb1));
        chk({tag, ".Busy2"}, 32'(Busy2), 32'(eb2));
        chk({tag, ".Stall"}, 32'(Stall), 32'(eb1 | eb2));
    endtask

    function automatic logic [23:0] exp_rd(input logic [3:0] a);
        if (a == 4'd0) return 24'd0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && Rd == a) return WriteD;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && Rd == a && a != 4'd0) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    initial begin
        n_chk = 0;
        n_fail = 0;
        clock = 1'b0;
        reset = 1'b1;
        drive(1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        wRegWrite = 1'b0; wRd = '0; wWriteD = '0; wIssue = 1'b0; wIssueRd = '0; wRs = '0; wRt = '0;

        //            we   rd    wd           iss  ird   rs    rt    e1      e2     b1    b2
        tbl[0]  = mk(1'b1, 4'd8, 24'd5,       1'b0, 4'd0, 4'd1, 4'd2, 24'd0,  24'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 4'd9, 24'd7,       1'b0, 4'd0, 4'd8, 4'd1, 24'd5,  24'd0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 4'd0, 24'd0,       1'b0, 4'd0, 4'd8, 4'd9, 24'd5,  24'd7, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 4'd0, 24'hABCDEF,  1'b0, 4'd0, 4'd8, 4'd9, 24'd5,  24'd7, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 4'd0, 24'd0,       1'b0, 4'd0, 4'd0, 4'd8, 24'd0,  24'd5, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 4'd0, 24'd0,       1'b1, 4'd3, 4'd3, 4'd0, 24'd0,  24'd0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 4'd0, 24'd0,       1'b0, 4'd0, 4'd3, 4'd3, 24'd0,  24'd0, 1'b1, 1'b1);
        tbl[7]  = mk(1'b1, 4'd3, 24'd9,       1'b0, 4'd0, 4'd0, 4'd8, 24'd0,  24'd5, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 4'd0, 24'd0,       1'b0, 4'd0, 4'd3, 4'd9, 24'd9,  24'd7, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 4'd3, 24'd11,      1'b1, 4'd3, 4'd4, 4'd4, 24'd0,  24'd0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 4'd0, 24'd0,       1'b0, 4'd0, 4'd3, 4'd8, 24'd11, 24'd5, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 4'd0, 24'd0,       1'b1, 4'd0, 4'd1, 4'd2, 24'd0,  24'd0, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 4'd0, 24'd0,       1'b0, 4'd0, 4'd0, 4'd0, 24'd0,  24'd0, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 4'd3, 24'd1,       1'b0, 4'd0, 4'd1, 4'd0, 24'd0,  24'd0, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 4'd0, 24'd0,       1'b0, 4'd0, 4'd3, 4'd3, 24'd1,  24'd1, 1'b0, 1'b0);

        // reset state
        #1;
        chk_all("reset_init", 24'd0, 24'd0, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;

        // vector table: outputs checked in the cycle before the row's edge
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].iss, tbl[i].ird, tbl[i].rs, tbl[i].rt);
            #2;
            chk_all($sformatf("tbl%0d", i), tbl[i].e1, tbl[i].e2, tbl[i].eb1, tbl[i].eb2);
            @(posedge clock); #1;
        end

        // bypass: reg5 busy holding 1, then writeback of 42 read in the same cycle
        drive(1'b1, 4'd5, 24'd1, 1'b1, 4'd5, 4'd0, 4'd0);
        @(posedge clock); #1;
        drive(1'b1, 4'd5, 24'd42, 1'b0, 4'd0, 4'd5, 4'd5);
        #2;
`ifdef REGFILE_BYPASS_EN
        chk_all("bypass_same", 24'd42, 24'd42, 1'b0, 1'b0);
`else
        chk_all("bypass_same", 24'd1, 24'd1, 1'b1, 1'b1);
`endif
        @(posedge clock); #1;
        drive(1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 4'd5, 4'd5);
        #2;
        chk_all("bypass_after", 24'd42, 24'd42, 1'b0, 1'b0);

        // asynchronous reset mid-cycle with a write and an issue pending
        @(posedge clock); #1;
        drive(1'b0, 4'd0, 24'd0, 1'b1, 4'd8, 4'd8, 4'd9);
        @(posedge clock); #1;
        drive(1'b1, 4'd8, 24'd77, 1'b1, 4'd9, 4'd8, 4'd9);
        #2;
        chk("pre_reset.Busy1", 32'(Busy1), 32'(`ifdef REGFILE_BYPASS_EN 1'b0 `else 1'b1 `endif));
        reset = 1'b1;
        #1;
        chk_all("async_reset", 24'd0, 24'd0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk_all("reset_hold", 24'd0, 24'd0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 4'd8, 4'd9);
        @(posedge clock); #1;
        chk_all("reset_after", 24'd0, 24'd0, 1'b0, 1'b0);

        // wide configuration with ordinary R0
        wRegWrite = 1'b1; wRd = 5'd0; wWriteD = 32'h00ABCDEF;
        @(posedge clock); #1;
        wRd = 5'd31; wWriteD = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        wRegWrite = 1'b0; wRs = 5'd0; wRt = 5'd31;
        #2;
        chk("wide_r0", wReadR1, 32'h00ABCDEF);
        chk("wide_r31", wReadR2, 32'hFFFF_FFFF);
        chk("wide_stall", 32'(wStall), 32'd0);
        for (int a = 1; a < 31; a++) begin
            wRs = 5'(a);
            #1;
            chk($sformatf("wide_untouched%0d", a), wReadR1, 32'd0);
        end

        // randomized traffic against the model (state is all-zero after the reset above)
        for (int a = 0; a < 16; a++) begin
            m_mem[a] = 24'd0;
            m_busy[a] = 1'b0;
        end
        @(posedge clock); #1;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 24'($urandom),
                  1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
            #2;
            chk_all($sformatf("rand%0d", c), exp_rd(Rs), exp_rd(Rt), exp_busy(Rs), exp_busy(Rt));
            @(posedge clock);
            if (RegWrite && Rd != 4'd0) m_mem[Rd] = WriteD;
            if (RegWrite && !(Issue && IssueRd == Rd)) m_busy[Rd] = 1'b0;
            if (Issue && IssueRd != 4'd0) m_busy[IssueRd] = 1'b1;
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
